// File: rtl/sr_latch_seq_ctrl_pkg.sv
// Shared state encodings, op codes and sizing helpers for the SR-latch sequencer.
// Pure definitions: no latency, no backpressure.
package sr_latch_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  // Counter must hold values up to the longer of the pulse and guard phases.
  function automatic int cnt_bits(input int pulse_w, input int gap_w);
    int longest;
    longest = (pulse_w > gap_w) ? pulse_w : gap_w;
    return $clog2(longest + 1);
  endfunction

  function automatic int idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sr_latch_seq_ctrl_rr_arbiter.sv
// Round-robin arbiter: first asserted req at or after ptr wins, one-hot grant plus index.
// Combinational, zero latency; no backpressure (grant is recomputed every cycle).
module sr_latch_seq_ctrl_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // ptr and i are both below N_REQ, so one subtraction folds the wrap.
      cand = 32'(ptr) + 32'(i);
      if (cand >= 32'(N_REQ)) begin
        cand = cand - 32'(N_REQ);
      end
      cand_idx = IDX_W'(cand);
      if (!grant_vld && req[cand_idx]) begin
        grant_vld       = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_latch_seq_ctrl.sv
// Shares one active-low SR latch among N_REQ requesters: arbitrate, pulse set_n/reset_n, guard, check q, ack.
// Latency 1+PULSE_W+GAP_W+1 cycles per grant; requesters hold req until ack, others wait their round-robin turn.
module sr_latch_seq_ctrl
  import sr_latch_seq_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_op,
  input  logic             latch_q,
  output logic             set_n,
  output logic             reset_n,
  output logic [N_REQ-1:0] ack,
  output logic             ack_ok,
  output logic             busy
);

  localparam int IDX_W = idx_bits(N_REQ);
  localparam int CNT_W = cnt_bits(PULSE_W, GAP_W);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);
  localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(N_REQ - 1);

  logic             q_meta_q, q_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic             op_q, op_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             set_n_q, set_n_d;
  logic             reset_n_q, reset_n_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             ack_ok_q, ack_ok_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;
  logic             arb_op;

  sr_latch_seq_ctrl_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  assign arb_op = |(req_op & arb_grant);

  // latch_q is asynchronous to clk; only q_s_q is ever consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta_q <= 1'b0;
      q_s_q    <= 1'b0;
    end else begin
      q_meta_q <= latch_q;
      q_s_q    <= q_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      gidx_q    <= '0;
      op_q      <= OP_RESET;
      ptr_q     <= '0;
      set_n_q   <= 1'b1;
      reset_n_q <= 1'b1;
      ack_q     <= '0;
      ack_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      op_q      <= op_d;
      ptr_q     <= ptr_d;
      set_n_q   <= set_n_d;
      reset_n_q <= reset_n_d;
      ack_q     <= ack_d;
      ack_ok_q  <= ack_ok_d;
    end
  end

  // Latch inputs default high; only PULSE (and the IDLE->PULSE edge) pulls exactly one of them low.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    op_d      = op_q;
    ptr_d     = ptr_q;
    set_n_d   = 1'b1;
    reset_n_d = 1'b1;
    ack_d     = '0;
    ack_ok_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (arb_vld) begin
          grant_d   = arb_grant;
          gidx_d    = arb_idx;
          op_d      = arb_op;
          set_n_d   = (arb_op != OP_SET);
          reset_n_d = (arb_op == OP_SET);
          state_d   = ST_PULSE;
        end
      end

      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          set_n_d   = (op_q != OP_SET);
          reset_n_d = (op_q == OP_SET);
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d    = '0;
          ack_d    = grant_q;
          ack_ok_d = (q_s_q == op_q);
          state_d  = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CHECK: begin
        ptr_d   = (gidx_q == IDX_MAX) ? '0 : gidx_q + IDX_W'(1);
        state_d = ST_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign set_n   = set_n_q;
  assign reset_n = reset_n_q;
  assign ack     = ack_q;
  assign ack_ok  = ack_ok_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr_latch_seq_ctrl.sv
// Bench for sr_latch_seq_ctrl: behavioural SR latch load, transaction-level model, scoreboard monitor.
module tb_sr_latch_seq_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] req_op;
  logic         latch_q;
  logic         set_n, reset_n;
  logic [N-1:0] ack;
  logic         ack_ok, busy;

  logic lq = 1'b0;
  bit   stuck = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_ptr = 0;

  int exp_idx[$];
  int exp_cyc[$];
  bit exp_ok[$];
  bit exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SR latch driven by the DUT.
  always @(set_n or reset_n) begin
    if (set_n === 1'b0) lq = 1'b1;
    else if (reset_n === 1'b0) lq = 1'b0;
  end

  assign latch_q = stuck ? 1'b0 : lq;

  sr_latch_seq_ctrl #(
    .N_REQ   (N),
    .PULSE_W (2),
    .GAP_W   (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_op  (req_op),
    .latch_q (latch_q),
    .set_n   (set_n),
    .reset_n (reset_n),
    .ack     (ack),
    .ack_ok  (ack_ok),
    .busy    (busy)
  );

  always @(negedge clk) begin
    logic [N-1:0] e_ack;
    int           ei, ec;
    bit           eo, eq;
    total++;
    if (!(set_n === 1'b1 || reset_n === 1'b1)) begin
      bad++;
      $display("FAIL safety_both_low: set_n=%b reset_n=%b required not both 0", set_n, reset_n);
    end
    total++;
    if (!$onehot0(ack)) begin
      bad++;
      $display("FAIL ack_onehot: ack=%b required one-hot or zero", ack);
    end
    if (rst_n === 1'b1 && ack !== '0) begin
      if (exp_idx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: ack=%b required none at cycle %0d", ack, cyc);
      end else begin
        ei = exp_idx.pop_front();
        eo = exp_ok.pop_front();
        eq = exp_q.pop_front();
        ec = exp_cyc.pop_front();
        e_ack = '0;
        e_ack[ei] = 1'b1;
        total++;
        if (ack !== e_ack) begin
          bad++;
          $display("FAIL ack_grant: ack=%b required %b", ack, e_ack);
        end
        total++;
        if (ack_ok !== eo) begin
          bad++;
          $display("FAIL ack_ok: got %b required %b (req %0d)", ack_ok, eo, ei);
        end
        total++;
        if (lq !== eq) begin
          bad++;
          $display("FAIL latch_q: got %b required %b (req %0d)", lq, eq, ei);
        end
        total++;
        if (cyc != ec) begin
          bad++;
          $display("FAIL ack_cycle: got %0d required %0d (req %0d)", cyc, ec, ei);
        end
      end
    end
  end

  // Predicts one burst: every masked requester served once, in cyclic order from the model pointer,
  // one transaction every 6 cycles starting 5 cycles after the request is raised.
  task automatic run_round(input logic [N-1:0] mask, input logic [N-1:0] ops, input bit one_shot);
    int c0, k, n, last;
    k = 0;
    last = m_ptr;
    @(negedge clk);
    c0 = cyc;
    for (int i = 0; i < N; i++) begin
      int id;
      id = (m_ptr + i) % N;
      if (mask[id]) begin
        exp_idx.push_back(id);
        exp_ok.push_back(stuck ? (ops[id] == 1'b0) : 1'b1);
        exp_q.push_back(ops[id]);
        exp_cyc.push_back(c0 + 5 + 6 * k);
        k++;
        last = id;
      end
    end
    m_ptr = (last + 1) % N;
    req_op = ops;
    req = mask;
    n = 0;
    while (exp_idx.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (one_shot) req = '0;
      else req = req & ~ack;
    end
    total++;
    if (exp_idx.size() != 0) begin
      bad++;
      $display("FAIL round_timeout: %0d acks outstanding, required 0 (mask %b)", exp_idx.size(), mask);
      exp_idx.delete();
      exp_ok.delete();
      exp_q.delete();
      exp_cyc.delete();
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic q_hold;
    logic [N-1:0] rm, ro;
    rst_n = 1'b0;
    req = '0;
    req_op = '0;
    repeat (3) @(negedge clk);
    chk("rst_set_n", set_n, 1'b1);
    chk("rst_reset_n", reset_n, 1'b1);
    chk("rst_ack", |ack, 1'b0);
    chk("rst_ack_ok", ack_ok, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (2) @(negedge clk);

    run_round(4'b0001, 4'b0001, 1'b0);
    run_round(4'b0001, 4'b0000, 1'b0);

    // Reset in the middle of a set pulse: outputs return high at once, latch untouched afterwards.
    @(negedge clk);
    req_op = 4'b0001;
    req = 4'b0001;
    @(posedge clk);
    #3;
    chk("pulse_active", set_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_set_n", set_n, 1'b1);
    chk("abort_reset_n", reset_n, 1'b1);
    chk("abort_ack", |ack, 1'b0);
    chk("abort_busy", busy, 1'b0);
    q_hold = lq;
    req = '0;
    repeat (3) @(negedge clk);
    chk("abort_q_hold", lq, q_hold);
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_q", lq, q_hold);
    chk("post_rst_busy", busy, 1'b0);

    run_round(4'b1111, 4'b0101, 1'b0);
    run_round(4'b1001, 4'b1000, 1'b0);
    run_round(4'b0100, 4'b0000, 1'b1);
    run_round(4'b0100, 4'b0000, 1'b0);

    stuck = 1'b1;
    run_round(4'b0001, 4'b0001, 1'b0);
    run_round(4'b0011, 4'b0001, 1'b0);
    stuck = 1'b0;
    run_round(4'b0010, 4'b0010, 1'b0);

    for (int r = 0; r < 25; r++) begin
      rm = 4'($urandom_range(1, 15));
      ro = 4'($urandom);
      stuck = ($urandom_range(0, 4) == 0);
      run_round(rm, ro, 1'b0);
      stuck = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
